// File: rtl/gpu_pkg.sv
// Shared encodings for the core scheduler and instruction fetcher.
// Also defines the PC type used by consumers of program memory.
package gpu_pkg;

    localparam int PC_BITS = 8;
    typedef logic [PC_BITS-1:0] pc_t;

    localparam logic [2:0] CORE_FETCH  = 3'b001;
    localparam logic [2:0] CORE_DECODE = 3'b010;

    typedef enum logic [2:0] {
        F_IDLE     = 3'b000,
        F_FETCHING = 3'b001,
        F_FETCHED  = 3'b010
    } fetch_state_e;

endpackage

// File: rtl/icache_fetcher_if.sv
// Read channel between the fetcher (master) and the program-memory controller (slave).
// A request is held until the controller raises ready, and ready is held until valid drops.
interface icache_fetcher_if #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16
);
    logic                 mem_read_valid;
    logic [ADDR_BITS-1:0] mem_read_address;
    logic                 mem_read_ready;
    logic [DATA_BITS-1:0] mem_read_data;

    modport master (
        output mem_read_valid,
        output mem_read_address,
        input  mem_read_ready,
        input  mem_read_data
    );

    modport slave (
        input  mem_read_valid,
        input  mem_read_address,
        output mem_read_ready,
        output mem_read_data
    );
endinterface

// File: rtl/icache_tag_array.sv
// Direct-mapped line storage: combinational lookup, synchronous fill, flush over fill.
// Only the valid bits are reset; tag/data contents are meaningless while invalid.
module icache_tag_array #(
    parameter int LINES     = 8,
    parameter int TAG_BITS  = 5,
    parameter int DATA_BITS = 16,
    parameter int IDX_BITS  = $clog2(LINES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic [IDX_BITS-1:0]  lu_idx,
    input  logic [TAG_BITS-1:0]  lu_tag,
    output logic                 lu_hit,
    output logic [DATA_BITS-1:0] lu_data,
    input  logic                 wr_en,
    input  logic [IDX_BITS-1:0]  wr_idx,
    input  logic [TAG_BITS-1:0]  wr_tag,
    input  logic [DATA_BITS-1:0] wr_data
);

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0]  tag_q  [LINES];
    logic [DATA_BITS-1:0] data_q [LINES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign lu_hit  = valid_q[lu_idx] && (tag_q[lu_idx] == lu_tag);
    assign lu_data = data_q[lu_idx];

endmodule

// File: rtl/icache_fetcher.sv
// Instruction fetcher: serves FETCH requests from a direct-mapped cache and
// refills misses from the program-memory controller over a held valid/ready channel.
module icache_fetcher
    import gpu_pkg::*;
#(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16,
    parameter int CACHE_LINES           = 8,
    parameter int COUNT_BITS            = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    input  logic                             flush,
    icache_fetcher_if.master                 mem,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
    output logic [COUNT_BITS-1:0]            hit_count,
    output logic [COUNT_BITS-1:0]            miss_count
);

    localparam int IDX_BITS = $clog2(CACHE_LINES);
    localparam int TAG_BITS = PROGRAM_MEM_ADDR_BITS - IDX_BITS;

    fetch_state_e                     state_q;
    logic                             rd_valid_q;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] rd_addr_q;
    logic [PROGRAM_MEM_DATA_BITS-1:0] instr_q;
    logic [COUNT_BITS-1:0]            hit_q;
    logic [COUNT_BITS-1:0]            miss_q;

    logic                             lu_hit;
    logic [PROGRAM_MEM_DATA_BITS-1:0] lu_data;
    logic                             fill_en;

    function automatic logic [COUNT_BITS-1:0] sat_inc(input logic [COUNT_BITS-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // The fill uses the held request address, not current_pc, so the line always matches the data.
    assign fill_en = (state_q == F_FETCHING) && mem.mem_read_ready;

    icache_tag_array #(
        .LINES     (CACHE_LINES),
        .TAG_BITS  (TAG_BITS),
        .DATA_BITS (PROGRAM_MEM_DATA_BITS),
        .IDX_BITS  (IDX_BITS)
    ) u_tags (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .lu_idx  (current_pc[IDX_BITS-1:0]),
        .lu_tag  (current_pc[PROGRAM_MEM_ADDR_BITS-1:IDX_BITS]),
        .lu_hit  (lu_hit),
        .lu_data (lu_data),
        .wr_en   (fill_en),
        .wr_idx  (rd_addr_q[IDX_BITS-1:0]),
        .wr_tag  (rd_addr_q[PROGRAM_MEM_ADDR_BITS-1:IDX_BITS]),
        .wr_data (mem.mem_read_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= F_IDLE;
            rd_valid_q <= 1'b0;
            rd_addr_q  <= '0;
            instr_q    <= '0;
            hit_q      <= '0;
            miss_q     <= '0;
        end else begin
            case (state_q)
                F_IDLE: begin
                    if (core_state == CORE_FETCH) begin
                        if (lu_hit) begin
                            instr_q <= lu_data;
                            hit_q   <= sat_inc(hit_q);
                            state_q <= F_FETCHED;
                        end else if (!mem.mem_read_ready) begin
                            // A still-high ready belongs to the previous response; wait for release.
                            rd_valid_q <= 1'b1;
                            rd_addr_q  <= current_pc;
                            miss_q     <= sat_inc(miss_q);
                            state_q    <= F_FETCHING;
                        end
                    end
                end
                F_FETCHING: begin
                    if (mem.mem_read_ready) begin
                        rd_valid_q <= 1'b0;
                        instr_q    <= mem.mem_read_data;
                        state_q    <= F_FETCHED;
                    end
                end
                F_FETCHED: begin
                    if (core_state == CORE_DECODE) begin
                        state_q <= F_IDLE;
                    end
                end
                default: state_q <= F_IDLE;
            endcase
        end
    end

    assign mem.mem_read_valid   = rd_valid_q;
    assign mem.mem_read_address = rd_addr_q;
    assign fetcher_state        = state_q;
    assign instruction          = instr_q;
    assign hit_count            = hit_q;
    assign miss_count           = miss_q;

endmodule

// File: doc/icache_fetcher.md
Name: icache_fetcher

Overview:
Per-core instruction fetcher with a small direct-mapped instruction cache. It sits directly upstream of the program-memory controller as one of that controller's consumers. On a FETCH request from the core scheduler it serves the instruction at current_pc from cache on a hit. On a miss it issues a read to the program-memory controller using the valid/ready hold-until-released handshake, then fills the cache line.

Parameters:
PROGRAM_MEM_ADDR_BITS, 8, width of the PC and program memory address
PROGRAM_MEM_DATA_BITS, 16, instruction width
CACHE_LINES, 8, number of one-instruction lines; power of 2, at least 2; IDX_BITS = log2(CACHE_LINES)
COUNT_BITS, 16, width of the hit and miss counters

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
core_state  in  3  scheduler state; FETCH=3'b001, DECODE=3'b010
current_pc  in  PROGRAM_MEM_ADDR_BITS  PC to fetch; stable while core_state==FETCH
flush  in  1  single-cycle pulse that invalidates all cache lines
mem_read_valid  out  1  read request to the controller
mem_read_address  out  PROGRAM_MEM_ADDR_BITS  request address
mem_read_ready  in  1  controller response valid; held until mem_read_valid drops
mem_read_data  in  PROGRAM_MEM_DATA_BITS  response data
fetcher_state  out  3  IDLE=3'b000, FETCHING=3'b001, FETCHED=3'b010
instruction  out  PROGRAM_MEM_DATA_BITS  fetched instruction; valid while fetcher_state==FETCHED
hit_count  out  COUNT_BITS  saturating hit counter
miss_count  out  COUNT_BITS  saturating miss counter

Behaviour:
- Reset values: fetcher_state=IDLE, mem_read_valid=0, mem_read_address=0, instruction=0, both counters 0, all line valid bits 0. Tag and data arrays need no reset.
- Address split: index=current_pc[IDX_BITS-1:0]; tag=current_pc[ADDR_BITS-1:IDX_BITS].
- IDLE:
  - Action is taken only when core_state==FETCH.
  - Hit (line valid and tag equal): instruction<=line data; hit_count++; next state FETCHED. Latency is 1 cycle.
  - Miss: mem_read_valid<=1; mem_read_address<=current_pc; miss_count++; next state FETCHING.
  - Miss guard: a miss while mem_read_ready is still 1 (controller has not released the previous response) stays in IDLE, issues nothing, and does not count; it retries the next cycle.
- FETCHING:
  - On mem_read_ready=1: mem_read_valid<=0; instruction<=mem_read_data; write the line (data, tag, valid=1); next state FETCHED.
  - Otherwise hold mem_read_valid=1 and keep mem_read_address stable. There is no timeout.
- FETCHED: hold instruction. When core_state==DECODE, next state is IDLE.
- Flush:
  - Clears all valid bits at the edge and is legal in any state.
  - Flush in the same cycle as a fill: flush wins and the line stays invalid. The instruction is still delivered and the state still goes to FETCHED.
  - Flush during FETCHING does not cancel the outstanding read.
  - Flush in the same cycle as an IDLE lookup: the lookup uses the pre-flush valid bits.
- Counters saturate at all-ones and do not wrap.
- Asynchronous reset mid-FETCHING drops mem_read_valid immediately. Any response that arrives later is ignored because the state is IDLE.
- core_state values other than FETCH and DECODE are ignored in every state.
- Consecutive FETCHes of the same PC hit after the first fill.

Decomposition:
- Shared package gpu_pkg holds:
  - the core_state encodings (FETCH, DECODE)
  - the fetcher_state encodings (IDLE, FETCHING, FETCHED)
  - a typedef for the PC width
- One natural sub-module, icache_tag_array:
  - holds the valid, tag and data arrays
  - provides a combinational lookup (hit, data) and a synchronous write port
  - provides flush with flush-over-write priority
- The FSM, handshake and counters stay in icache_fetcher.

Test Plan:
- Cold miss: reset; FETCH with pc=0x05; memory responds with 0x1234 after 3 cycles -> mem_read_valid=1 with address 0x05 until ready; FETCHED with instruction=0x1234; miss_count=1.
- Hit: after the above, DECODE then FETCH pc=0x05 -> FETCHED one cycle later with 0x1234, no mem_read_valid pulse; hit_count=1.
- Conflict: fill pc=0x05, then FETCH pc=0x0D (same index when CACHE_LINES=8) -> miss; line replaced; a following FETCH of 0x05 misses again (miss_count=3).
- Flush priority: assert flush on the cycle mem_read_ready rises for pc=0x02 -> instruction delivered; the next FETCH of 0x02 misses.
- Handshake guard: hold mem_read_ready=1 for 2 extra cycles after the fill, then issue a new miss FETCH -> mem_read_valid stays 0 until ready is low, then asserts.
- Async reset during FETCHING: assert reset mid-cycle -> mem_read_valid and fetcher_state go to 0 before the next edge; counters read 0.
